// File: rtl/hex7seg_pkg.sv
`default_nettype none
// ============================================================================
//  hex7seg_pkg : segment indices, all-on/off patterns and hex glyph table
//  Rev 1.0
// ============================================================================
package hex7seg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_ALL_ON  = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_ALL_OFF = 7'b0000000;

  // Active-high abcdefg glyphs; 0xB and 0xD are the lowercase forms.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage : hex7seg_pkg
`default_nettype wire

// File: rtl/hex_to_7seg_if.sv
`default_nettype none
// ============================================================================
//  hex_to_7seg_if : digit value/control in, segment pattern out
//  Rev 1.0
// ============================================================================
interface hex_to_7seg_if;
  import hex7seg_pkg::*;

  logic [3:0]       x;
  logic             en;
  logic             blank;
  logic             lamp_test;
  logic [SEG_W-1:0] z;

  modport master (
    output x,
    output en,
    output blank,
    output lamp_test,
    input  z
  );

  modport slave (
    input  x,
    input  en,
    input  blank,
    input  lamp_test,
    output z
  );

endinterface : hex_to_7seg_if
`default_nettype wire

// File: rtl/hex_seg_lut.sv
`default_nettype none
// ============================================================================
//  hex_seg_lut : combinational nibble -> active-high abcdefg pattern
//  Rev 1.0
// ============================================================================
module hex_seg_lut
  import hex7seg_pkg::*;
(
  input  wire logic [3:0]       nibble,
  output logic      [SEG_W-1:0] seg
);

  always_comb begin
    seg = GLYPH_TABLE[nibble];
  end

endmodule : hex_seg_lut
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
//  hex_to_7seg : registered hex-to-seven-segment decoder with blank/lamp test
//  Rev 1.0
// ============================================================================
module hex_to_7seg
  import hex7seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hex_to_7seg_if.slave       bus
);

  localparam logic [SEG_W-1:0] POL_MASK = {SEG_W{ACTIVE_LOW}};

  logic [SEG_W-1:0] glyph;
  logic [SEG_W-1:0] sel;
  logic [SEG_W-1:0] z_d;
  logic [SEG_W-1:0] z_q;

  hex_seg_lut u_lut (
    .nibble (bus.x),
    .seg    (glyph)
  );

  // Polarity is applied after the priority mux so every source inverts alike.
  always_comb begin
    sel = glyph;
    z_d = z_q;
    if (bus.lamp_test) begin
      sel = SEG_ALL_ON;
    end else if (bus.blank) begin
      sel = SEG_ALL_OFF;
    end
    if (bus.en) begin
      z_d = sel ^ POL_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= SEG_ALL_OFF ^ POL_MASK;
    end else begin
      z_q <= z_d;
    end
  end

  assign bus.z = z_q;

endmodule : hex_to_7seg
`default_nettype wire

// File: tb/tb_hex_to_7seg.sv
`default_nettype none
// ============================================================================
//  tb_hex_to_7seg : drives both polarities in parallel against a reference model
//  Rev 1.0
// ============================================================================
module tb_hex_to_7seg;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_r   = 1'b1;
  logic [3:0] x_r     = 4'd8;
  logic       en_r    = 1'b1;
  logic       blank_r = 1'b0;
  logic       lamp_r  = 1'b0;

  hex_to_7seg_if if_ah ();
  hex_to_7seg_if if_al ();

  assign if_ah.x = x_r;  assign if_ah.en = en_r;
  assign if_ah.blank = blank_r;  assign if_ah.lamp_test = lamp_r;
  assign if_al.x = x_r;  assign if_al.en = en_r;
  assign if_al.blank = blank_r;  assign if_al.lamp_test = lamp_r;

  hex_to_7seg #(.ACTIVE_LOW(1'b0)) dut_ah (.clk(clk), .rst(rst_r), .bus(if_ah));
  hex_to_7seg #(.ACTIVE_LOW(1'b1)) dut_al (.clk(clk), .rst(rst_r), .bus(if_al));

  // Reference glyphs written straight from the decode table (abcdefg, lit=1).
  logic [6:0] ref_glyph [16];
  initial begin
    ref_glyph[0]  = 7'b1111110; ref_glyph[1]  = 7'b0110000;
    ref_glyph[2]  = 7'b1101101; ref_glyph[3]  = 7'b1111001;
    ref_glyph[4]  = 7'b0110011; ref_glyph[5]  = 7'b1011011;
    ref_glyph[6]  = 7'b1011111; ref_glyph[7]  = 7'b1110000;
    ref_glyph[8]  = 7'b1111111; ref_glyph[9]  = 7'b1111011;
    ref_glyph[10] = 7'b1110111; ref_glyph[11] = 7'b0011111;
    ref_glyph[12] = 7'b1001110; ref_glyph[13] = 7'b0111101;
    ref_glyph[14] = 7'b1001111; ref_glyph[15] = 7'b1000111;
  end

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_hi = 7'b0000000;   // model of the lit-segment view

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare both DUTs just after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_r)        exp_hi = 7'b0000000;
    else if (en_r) begin
      if (lamp_r)       exp_hi = 7'b1111111;
      else if (blank_r) exp_hi = 7'b0000000;
      else              exp_hi = ref_glyph[x_r];
    end
    #1;
    check({tag, "_ah"}, if_ah.z, exp_hi);
    check({tag, "_al"}, if_al.z, ~exp_hi);
  endtask

  task automatic drive(input logic r, input logic e, input logic b,
                       input logic l, input logic [3:0] xv);
    rst_r = r; en_r = e; blank_r = b; lamp_r = l; x_r = xv;
  endtask

  initial begin
    // Reset with x=8, en=1 for two edges.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd8);
    tick("reset0");
    tick("reset1");
    check("reset_lit", if_ah.z, 7'b0000000);
    check("reset_al_lit", if_al.z, 7'b1111111);

    // Reset released with en=0: stays all off.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
    tick("post_reset_hold");
    check("post_reset_off", if_ah.z, 7'b0000000);

    // Sweep 0..F with a one-cycle reset pulse at x=6.
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd6);
        tick("mid_reset");
        check("mid_reset_lit", if_ah.z, 7'b0000000);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'(i));
      tick("sweep");
      if (i == 0)  check("sweep_0",  if_ah.z, 7'b1111110);
      if (i == 6)  check("sweep_6",  if_ah.z, 7'b1011111);
      if (i == 10) check("sweep_A",  if_ah.z, 7'b1110111);
      if (i == 15) check("sweep_F",  if_ah.z, 7'b1000111);
    end

    // Hold.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    tick("hold_load");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    tick("hold_a");
    tick("hold_b");
    check("hold_lit", if_ah.z, 7'b1111001);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    tick("hold_release");
    check("hold_release_lit", if_ah.z, 7'b0110011);

    // Priority.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
    tick("prio_blank");
    check("prio_blank_lit", if_ah.z, 7'b0000000);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd1);
    tick("prio_lamp");
    check("prio_lamp_lit", if_ah.z, 7'b1111111);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tick("prio_none");
    check("prio_none_lit", if_ah.z, 7'b0110000);

    // Polarity literals on the active-low instance.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick("pol_0");
    check("pol_0_lit", if_al.z, 7'b0000001);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
    tick("pol_8");
    check("pol_8_lit", if_al.z, 7'b0000000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd8);
    tick("pol_blank");
    check("pol_blank_lit", if_al.z, 7'b1111111);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 6) == 0),
            4'($urandom_range(0, 15)));
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hex_to_7seg
`default_nettype wire
